fpnew_sdotp_arbiter: RTL

- Shares one fpnew_sdotp_multi_wrapper instance among NumReq independent requesters, for example several FPU lanes or cores in a cluster.
- Grants requests round-robin, tags each issued operation with the requester index, and routes each in-order result back to its originator.
- Limits every requester to MaxOutstanding in-flight operations with a per-requester credit counter.
- Sits between requester-side valid/ready ports and the sdotp unit's input/output handshakes.

---
 rtl/fpnew_sdotp_arbiter.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/fpnew_sdotp_arbiter.sv
// Round-robin arbiter sharing one sdotp unit among NumReq requesters.
// Tags each issue with the requester index and routes results back by tag.
module fpnew_sdotp_arbiter #(
  parameter int unsigned NumReq         = 4,
  parameter int unsigned DataWidth      = 200,
  parameter int unsigned ResWidth       = 64,
  parameter int unsigned MaxOutstanding = 4,
  parameter int unsigned IdxWidth       = $clog2(NumReq)
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        flush_i,
  input  logic [NumReq-1:0]           req_valid_i,
  output logic [NumReq-1:0]           req_ready_o,
  input  logic [NumReq*DataWidth-1:0] req_data_i,
  output logic [NumReq-1:0]           rsp_valid_o,
  input  logic [NumReq-1:0]           rsp_ready_i,
  output logic [ResWidth-1:0]         rsp_result_o,
  output logic [4:0]                  rsp_status_o,
  output logic                        unit_valid_o,
  input  logic                        unit_ready_i,
  output logic [DataWidth-1:0]        unit_data_o,
  output logic [IdxWidth-1:0]         unit_tag_o,
  output logic                        unit_flush_o,
  input  logic                        unit_valid_i,
  output logic                        unit_ready_o,
  input  logic [ResWidth-1:0]         unit_result_i,
  input  logic [4:0]                  unit_status_i,
  input  logic [IdxWidth-1:0]         unit_tag_i,
  output logic                        busy_o
);

  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

  logic [CntW-1:0]     cnt_q [NumReq];
  logic [CntW-1:0]     cnt_d [NumReq];
  logic [IdxWidth-1:0] ptr_q, ptr_d;
  logic [IdxWidth-1:0] lidx_q, lidx_d;
  logic                lock_q, lock_d;
  logic                busy_q, busy_d;

  logic [NumReq-1:0]   elig;
  logic [IdxWidth-1:0] win;
  logic                any_elig;
  logic                act;
  logic                issue;
  logic                rsp_fire;
  logic                tag_ok;

  // Outputs are gated by reset so they drop immediately on async reset.
  assign act = rst_ni && !flush_i;

  always_comb begin
    for (int i = 0; i < NumReq; i++) begin
      elig[i] = req_valid_i[i] && (cnt_q[i] < CntW'(MaxOutstanding));
    end
  end

  // Reverse scan: the last hit is the closest eligible index at/after ptr.
  always_comb begin
    int unsigned j;
    win      = ptr_q;
    any_elig = 1'b0;
    j        = 0;
    for (int k = NumReq - 1; k >= 0; k--) begin
      j = (int'(ptr_q) + k) % NumReq;
      if (elig[j]) begin
        win      = IdxWidth'(j);
        any_elig = 1'b1;
      end
    end
    if (lock_q) begin
      win      = lidx_q;
      any_elig = 1'b1;
    end
  end

  assign unit_valid_o = act && any_elig;
  assign issue        = unit_valid_o && unit_ready_i;
  assign unit_tag_o   = unit_valid_o ? win : '0;
  assign unit_data_o  = unit_valid_o ?
                        req_data_i[int'(win)*DataWidth +: DataWidth] : '0;
  assign unit_flush_o = flush_i;

  always_comb begin
    req_ready_o = '0;
    if (unit_valid_o) req_ready_o[win] = unit_ready_i;
  end

  assign tag_ok       = int'(unit_tag_i) < NumReq;
  assign unit_ready_o = act && tag_ok && rsp_ready_i[unit_tag_i];
  assign rsp_fire     = unit_valid_i && unit_ready_o;
  assign rsp_result_o = unit_result_i;
  assign rsp_status_o = unit_status_i;

  always_comb begin
    for (int k = 0; k < NumReq; k++) begin
      rsp_valid_o[k] = act && unit_valid_i && (unit_tag_i == IdxWidth'(k));
    end
  end

  always_comb begin
    logic inc, dec;
    inc = 1'b0;
    dec = 1'b0;
    for (int i = 0; i < NumReq; i++) begin
      cnt_d[i] = cnt_q[i];
      inc      = issue && (win == IdxWidth'(i));
      dec      = rsp_fire && (unit_tag_i == IdxWidth'(i));
      if (flush_i)          cnt_d[i] = '0;
      else if (inc && !dec) cnt_d[i] = cnt_q[i] + 1'b1;
      else if (dec && !inc) cnt_d[i] = cnt_q[i] - 1'b1;
    end
  end

  always_comb begin
    ptr_d  = ptr_q;
    lock_d = lock_q;
    lidx_d = lidx_q;
    busy_d = unit_valid_o;
    if (issue) begin
      ptr_d = (int'(win) == NumReq - 1) ? '0 : win + 1'b1;
    end
    if (flush_i || issue) begin
      lock_d = 1'b0;
    end else if (unit_valid_o) begin
      lock_d = 1'b1;
      lidx_d = win;
    end
    for (int i = 0; i < NumReq; i++) begin
      if (cnt_d[i] != '0) busy_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumReq; i++) cnt_q[i] <= '0;
      ptr_q  <= '0;
      lidx_q <= '0;
      lock_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      for (int i = 0; i < NumReq; i++) cnt_q[i] <= cnt_d[i];
      ptr_q  <= ptr_d;
      lidx_q <= lidx_d;
      lock_q <= lock_d;
      busy_q <= busy_d;
    end
  end

  assign busy_o = busy_q;

  a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    rsp_fire |-> (cnt_q[unit_tag_i] != '0));

endmodule
